// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
//   Shared definitions for the GCD traffic client:
//     - state_t : FSM state encoding (IDLE/SEND/WAIT/DONE)
//     - LFSR_TAPS, DEFAULT_SEED : operand generator constants
//     - sat_inc16 : saturating 16-bit increment used by the latency logic
// -----------------------------------------------------------------------------
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/gcd_client_if.sv
// -----------------------------------------------------------------------------
// gcd_client_if
//   Operand and result channels between the traffic client (master) and the
//   GCD unit (slave).
//
//   Handshake: each channel is a val/rdy pair. A transfer ("fire") happens on
//   a rising clock edge where val and rdy are both high. The producer keeps
//   val and its data stable until the fire; the consumer may raise or lower
//   rdy freely and must not depend on it combinationally from val.
//
//   Ports (master view):
//     operands_val / operands_bits_A / operands_bits_B : out
//     operands_rdy                                     : in
//     result_val / result_bits                         : in
//     result_rdy                                       : out
// -----------------------------------------------------------------------------
interface gcd_client_if #(
    parameter int W = 16
);
    logic         operands_val;
    logic         operands_rdy;
    logic [W-1:0] operands_bits_A;
    logic [W-1:0] operands_bits_B;
    logic         result_val;
    logic         result_rdy;
    logic [W-1:0] result_bits;

    modport master (
        output operands_val, operands_bits_A, operands_bits_B, result_rdy,
        input  operands_rdy, result_val, result_bits
    );

    modport slave (
        input  operands_val, operands_bits_A, operands_bits_B, result_rdy,
        output operands_rdy, result_val, result_bits
    );
endinterface

// File: rtl/gcd_lfsr.sv
// -----------------------------------------------------------------------------
// gcd_lfsr
//   32-bit Galois LFSR, right-shifting, taps LFSR_TAPS. Steps once per cycle
//   in which adv is high; reloads SEED on reset so runs are repeatable.
//
//   Ports:
//     clk   : in  clock
//     reset : in  synchronous, active-high
//     adv   : in  advance one step
//     q     : out current LFSR state
// -----------------------------------------------------------------------------
module gcd_lfsr
    import gcd_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        adv,
    output logic [31:0] q
);

    logic [31:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= SEED;
        end else if (adv) begin
            // Bit shifted out of the LSB feeds back through the tap mask.
            r_q <= {1'b0, r_q[31:1]} ^ (r_q[0] ? LFSR_TAPS : 32'h0);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/gcd_client.sv
// -----------------------------------------------------------------------------
// gcd_client
//   Traffic initiator/sink for the GCD unit. On start it sends NUM_REQ operand
//   pairs drawn from an LFSR, one transaction outstanding at a time, and
//   consumes each result. Tracks request/response counts, a wrapping checksum
//   of results and the worst fire-to-fire latency (saturating).
//
//   Parameters: W (operand width, 1..16), NUM_REQ (0..65535), SEED (non-zero).
//
//   Optional feature (macro GCD_CLIENT_RDY_THROTTLE_EN): a free-running toggle
//   gates result_rdy so results are accepted only on alternate cycles.
//
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     start             : in  one-cycle pulse, begins a run from IDLE/DONE
//     busy / done       : out run in progress / run finished
//     gcd               : operand and result channels (master modport)
//     req_count         : out operand fires this run
//     resp_count        : out result fires this run
//     checksum          : out sum of accepted results mod 2^W
//     max_latency       : out worst operand-fire to result-fire latency
//     dbg_state         : out current FSM state
// -----------------------------------------------------------------------------
module gcd_client
    import gcd_pkg::*;
#(
    parameter int          W       = 16,
    parameter int          NUM_REQ = 16,
    parameter logic [31:0] SEED    = DEFAULT_SEED
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    gcd_client_if.master        gcd,
    output logic [15:0]         req_count,
    output logic [15:0]         resp_count,
    output logic [W-1:0]        checksum,
    output logic [15:0]         max_latency,
    output state_t              dbg_state
);

    localparam logic [16:0] NUM_REQ_L = 17'(NUM_REQ);

    state_t       r_state;
    logic         r_busy;
    logic         r_done;
    logic         r_op_val;
    logic [15:0]  r_req_count;
    logic [15:0]  r_resp_count;
    logic [W-1:0] r_checksum;
    logic [15:0]  r_max_lat;
    logic [15:0]  r_lat;

    logic [31:0]  w_lfsr;
    logic         w_res_rdy;
    logic         w_op_fire;
    logic         w_res_fire;
    logic [15:0]  w_lat_plus1;
    logic         w_last;

    gcd_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (w_op_fire),
        .q     (w_lfsr)
    );

`ifdef GCD_CLIENT_RDY_THROTTLE_EN
    logic r_toggle;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_toggle <= 1'b0;
        end else begin
            r_toggle <= ~r_toggle;
        end
    end

    assign w_res_rdy = (r_state == WAIT) && r_toggle;
`else
    assign w_res_rdy = (r_state == WAIT);
`endif

    // r_op_val is only ever high in SEND, so it doubles as the SEND qualifier.
    assign w_op_fire   = r_op_val && gcd.operands_rdy;
    assign w_res_fire  = w_res_rdy && gcd.result_val;
    // Latency counts the fire cycle itself, hence +1 on top of the wait count.
    assign w_lat_plus1 = sat_inc16(r_lat);
    assign w_last      = ({1'b0, r_resp_count} + 17'd1) >= NUM_REQ_L;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_op_val     <= 1'b0;
            r_req_count  <= 16'd0;
            r_resp_count <= 16'd0;
            r_checksum   <= '0;
            r_max_lat    <= 16'd0;
            r_lat        <= 16'd0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_req_count  <= 16'd0;
                        r_resp_count <= 16'd0;
                        r_checksum   <= '0;
                        r_max_lat    <= 16'd0;
                        r_lat        <= 16'd0;
                        if (NUM_REQ_L == 17'd0) begin
                            // Empty run: straight to DONE, busy never rises.
                            r_state  <= DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_state  <= SEND;
                            r_busy   <= 1'b1;
                            r_done   <= 1'b0;
                            r_op_val <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (w_op_fire) begin
                        r_req_count <= r_req_count + 16'd1;
                        r_lat       <= 16'd0;
                        r_op_val    <= 1'b0;
                        r_state     <= WAIT;
                    end
                end

                WAIT: begin
                    if (w_res_fire) begin
                        r_resp_count <= r_resp_count + 16'd1;
                        r_checksum   <= r_checksum + gcd.result_bits;
                        if (w_lat_plus1 > r_max_lat) begin
                            r_max_lat <= w_lat_plus1;
                        end
                        if (w_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= SEND;
                            r_op_val <= 1'b1;
                        end
                    end else begin
                        r_lat <= sat_inc16(r_lat);
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy                = r_busy;
    assign done                = r_done;
    assign gcd.operands_val    = r_op_val;
    assign gcd.operands_bits_A = w_lfsr[W-1:0];
    assign gcd.operands_bits_B = w_lfsr[W+15:16];
    assign gcd.result_rdy      = w_res_rdy;
    assign req_count           = r_req_count;
    assign resp_count          = r_resp_count;
    assign checksum            = r_checksum;
    assign max_latency         = r_max_lat;
    assign dbg_state           = r_state;

endmodule
